beta_trap_ctrl: RTL

Trap control unit (TCU) and consumer of the trap codes raised by fetch/decode and the LSU. Prioritises synchronous exceptions and machine interrupts, and owns the trap CSRs mstatus.MIE/MPIE, mepc, mcause and mtval. It redirects the pipeline to the mtvec target on trap entry and to mepc on mret, using a valid/ready redirect handshake with the fetch stage.

---
 rtl/beta_trap_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/beta_trap_ctrl.sv
// Trap control unit: prioritises exceptions and machine interrupts, owns the trap CSRs,
// and redirects fetch to the trap vector on entry and to mepc on mret.
module beta_trap_ctrl #(
  parameter int   XLEN    = 32,
  parameter logic MIE_RST = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      instr_trap_i,
  input  logic [XLEN-1:0] instr_pc_i,
  input  logic [31:0]     instr_word_i,
  input  logic [XLEN-1:0] fetch_addr_i,
  input  logic [1:0]      lsu_trap_i,
  input  logic [XLEN-1:0] lsu_pc_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            irq_boundary_i,
  input  logic            msip_i,
  input  logic            mtip_i,
  input  logic            meip_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            mret_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [1:0]      trap_type_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o
);

  localparam logic [1:0] INSTR_MISALIG_FETCH = 2'd1;
  localparam logic [1:0] INSTR_ILLEGAL_FETCH = 2'd2;
  localparam logic [1:0] LSU_MISALIG_LOAD    = 2'd1;
  localparam logic [1:0] LSU_MISALIG_STORE   = 2'd2;
  localparam logic [1:0] TCU_NOTRAP          = 2'd0;
  localparam logic [1:0] TCU_INTERRUPT       = 2'd1;
  localparam logic [1:0] TCU_EXCEPTION       = 2'd2;

  localparam logic [4:0] INSTR_ADDR_MISALIGNED = 5'h00;
  localparam logic [4:0] INSTR_ILLEGAL         = 5'h02;
  localparam logic [4:0] LOAD_ADDR_MISALIGNED  = 5'h04;
  localparam logic [4:0] STORE_ADDR_MISALIGNED = 5'h06;
  localparam logic [4:0] MSW_INT               = 5'h13;
  localparam logic [4:0] MTIM_INT              = 5'h17;
  localparam logic [4:0] MEXT_INT              = 5'h1B;

  typedef enum logic [1:0] {RUN, ENTER, RETURN, REDIRECT} state_e;

  state_e          state;
  logic            mie_q, mpie_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q;
  logic [1:0]      trap_type_q;
  logic            flush_q, redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            take;
  logic            is_int;
  logic [4:0]      cause;
  logic [XLEN-1:0] trap_epc, trap_tval, trap_mcause;
  logic [XLEN-1:0] vec_base, vec_target;
  logic            unused_mie;

  assign unused_mie = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  // Trap arbitration; reserved code 2'b11 on either source falls through as no trap.
  always_comb begin
    take      = 1'b0;
    is_int    = 1'b0;
    cause     = 5'h00;
    trap_epc  = '0;
    trap_tval = '0;
    if (lsu_trap_i == LSU_MISALIG_LOAD || lsu_trap_i == LSU_MISALIG_STORE) begin
      take      = 1'b1;
      cause     = (lsu_trap_i == LSU_MISALIG_LOAD) ? LOAD_ADDR_MISALIGNED : STORE_ADDR_MISALIGNED;
      trap_epc  = lsu_pc_i;
      trap_tval = lsu_addr_i;
    end else if (instr_trap_i == INSTR_MISALIG_FETCH) begin
      take      = 1'b1;
      cause     = INSTR_ADDR_MISALIGNED;
      trap_epc  = instr_pc_i;
      trap_tval = fetch_addr_i;
    end else if (instr_trap_i == INSTR_ILLEGAL_FETCH) begin
      take      = 1'b1;
      cause     = INSTR_ILLEGAL;
      trap_epc  = instr_pc_i;
      trap_tval = XLEN'(instr_word_i);
    end else if (mie_q && irq_boundary_i) begin
      trap_epc = next_pc_i;
      if (meip_i && mie_i[11]) begin
        take = 1'b1; is_int = 1'b1; cause = MEXT_INT;
      end else if (msip_i && mie_i[3]) begin
        take = 1'b1; is_int = 1'b1; cause = MSW_INT;
      end else if (mtip_i && mie_i[7]) begin
        take = 1'b1; is_int = 1'b1; cause = MTIM_INT;
      end
    end
  end

  assign trap_mcause = {cause[4], {(XLEN-5){1'b0}}, cause[3:0]};

  // Vectored mode only applies to interrupts; mode 1x falls back to direct.
  assign vec_base   = {mtvec_i[XLEN-1:2], 2'b00};
  assign vec_target = (trap_type_q == TCU_INTERRUPT && mtvec_i[1:0] == 2'b01)
                    ? vec_base + {{(XLEN-6){1'b0}}, mcause_q[3:0], 2'b00}
                    : vec_base;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= RUN;
      mie_q            <= MIE_RST;
      mpie_q           <= 1'b0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      trap_type_q      <= TCU_NOTRAP;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (take) begin
            mepc_q      <= {trap_epc[XLEN-1:2], 2'b00};
            mcause_q    <= trap_mcause;
            mtval_q     <= trap_tval;
            mpie_q      <= mie_q;
            mie_q       <= 1'b0;
            trap_type_q <= is_int ? TCU_INTERRUPT : TCU_EXCEPTION;
            flush_q     <= 1'b1;
            state       <= ENTER;
          end else begin
            if (csr_we_i) begin
              case (csr_addr_i)
                12'h300: begin
                  mie_q  <= csr_wdata_i[3];
                  mpie_q <= csr_wdata_i[7];
                end
                12'h341: mepc_q   <= {csr_wdata_i[XLEN-1:2], 2'b00};
                12'h342: mcause_q <= csr_wdata_i;
                12'h343: mtval_q  <= csr_wdata_i;
                default: ;
              endcase
            end
            // mret takes precedence over a simultaneous mstatus write.
            if (mret_i) begin
              mie_q   <= mpie_q;
              mpie_q  <= 1'b1;
              flush_q <= 1'b1;
              state   <= RETURN;
            end
          end
        end
        ENTER: begin
          trap_type_q      <= TCU_NOTRAP;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= vec_target;
          state            <= REDIRECT;
        end
        RETURN: begin
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= mepc_q;
          state            <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            redirect_valid_q <= 1'b0;
            state            <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    mstatus_o      = '0;
    mstatus_o[3]   = mie_q;
    mstatus_o[7]   = mpie_q;
    mstatus_o[12:11] = 2'b11;
  end

  assign trap_type_o      = trap_type_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign mepc_o           = mepc_q;
  assign mcause_o         = mcause_q;
  assign mtval_o          = mtval_q;

endmodule
